// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared types and constants for the 7-segment scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Number of multiplexed digits handled by the scan controller.
    localparam int N_DIGITS = 4;

    // Active-low segment pattern with every segment dark.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low anode pattern with every digit disabled.
    localparam logic [N_DIGITS-1:0] ANODES_OFF = 4'b1111;

    // Scan sequencer states: dead time before a digit, then the digit lit.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/display_bin_hex.sv
`default_nettype none
// ============================================================================
//  Module      : display_bin_hex
//  Description : Hex nibble to common-anode 7-segment decoder, {a..g}
//                active-low. Code F renders dark so it doubles as a blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_bin_hex (
    input  logic [3:0] switch,
    output logic [6:0] seven
);

    // Pure lookup from nibble to segment pattern.
    always_comb begin
        seven = 7'b1111111;
        case (switch)
            4'h0: seven = 7'b0000001;
            4'h1: seven = 7'b1001111;
            4'h2: seven = 7'b0010010;
            4'h3: seven = 7'b0000110;
            4'h4: seven = 7'b1001100;
            4'h5: seven = 7'b0100100;
            4'h6: seven = 7'b0100000;
            4'h7: seven = 7'b0001111;
            4'h8: seven = 7'b0000000;
            4'h9: seven = 7'b0000100;
            4'hA: seven = 7'b0001000;
            4'hB: seven = 7'b1100000;
            4'hC: seven = 7'b0110001;
            4'hD: seven = 7'b1000010;
            4'hE: seven = 7'b0110000;
            default: seven = 7'b1111111;
        endcase
    end

endmodule : display_bin_hex
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_ctrl
//  Description : Time-multiplexed 4-digit 7-segment scan controller with a
//                double-buffered value, per-digit dead time and optional
//                leading-zero blanking. One shared hex decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 25000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [15:0]         value,
    input  logic                load,
    input  logic                lz_blank,
    output logic [N_DIGITS-1:0] anodes,
    output logic [6:0]          seven,
    output logic                frame_done
);

    localparam int c_cnt_max = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_idx_w   = $clog2(N_DIGITS);

    localparam logic [c_cnt_w-1:0]  c_dead_last    = c_cnt_w'(DEAD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_refresh_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last     = c_idx_w'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] c_digit0       = N_DIGITS'(1);

    scan_state_t          r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_idx;
    logic [15:0]          r_shadow;
    logic [15:0]          r_disp;
    logic [3:0]           r_nibble;
    logic                 r_lit;
    logic [N_DIGITS-1:0]  r_anodes;
    logic                 r_frame_done;

    logic [3:0]           w_nibble;
    logic                 w_upper_zero;
    logic                 w_lz;
    logic [6:0]           w_dec;

    // Nibble of the display register belonging to the current digit index.
    assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];

    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 never is.
    always_comb begin
        w_upper_zero = 1'b0;
        case (r_idx)
            2'd1:    w_upper_zero = (r_disp[15:4]  == 12'h000);
            2'd2:    w_upper_zero = (r_disp[15:8]  == 8'h00);
            2'd3:    w_upper_zero = (r_disp[15:12] == 4'h0);
            default: w_upper_zero = 1'b0;
        endcase
    end

    assign w_lz = lz_blank & w_upper_zero;

    // Scan sequencer, shadow/display double buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= 16'h0000;
            r_disp       <= 16'h0000;
            r_nibble     <= 4'h0;
            r_lit        <= 1'b0;
            r_anodes     <= ANODES_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (load) begin
                r_shadow <= value;
            end
            if (!en) begin
                r_state  <= BLANK;
                r_cnt    <= '0;
                r_idx    <= '0;
                r_lit    <= 1'b0;
                r_anodes <= ANODES_OFF;
            end else begin
                case (r_state)
                    BLANK: begin
                        if (r_cnt == c_dead_last) begin
                            // Nibble and anode switch together so segments never
                            // appear on the wrong digit.
                            r_state  <= SHOW;
                            r_cnt    <= '0;
                            r_nibble <= w_nibble;
                            r_lit    <= ~w_lz;
                            r_anodes <= w_lz ? ANODES_OFF : ~(c_digit0 << r_idx);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    SHOW: begin
                        if (r_cnt == c_refresh_last) begin
                            r_state  <= BLANK;
                            r_cnt    <= '0;
                            r_idx    <= r_idx + 1'b1;
                            r_lit    <= 1'b0;
                            r_anodes <= ANODES_OFF;
                            // Frame boundary: the old shadow is committed, so a
                            // load landing on this same edge waits one frame.
                            if (r_idx == c_idx_last) begin
                                r_disp       <= r_shadow;
                                r_frame_done <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    display_bin_hex u_dec (
        .switch (r_nibble),
        .seven  (w_dec)
    );

    assign seven      = r_lit ? w_dec : SEG_BLANK;
    assign anodes     = r_anodes;
    assign frame_done = r_frame_done;

endmodule : display_scan_ctrl
`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It shares one hex-to-segment decoder across all digits by sequencing digit index, anode enables and the nibble fed to the decoder. It double-buffers the displayed value so updates only take effect at frame boundaries, and inserts dead time between digits to suppress ghosting. It sits between the application datapath (16-bit value) and the board display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits; fixed at 4 for this revision.
REFRESH_DIV, 25000, clk cycles a digit stays lit per slot; must be >=1.
DEAD_CYCLES, 16, clk cycles all anodes are off before each digit; must be >=1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  scan enable; low forces display dark and restarts the scan
value  in  16  hex value to show, digit 0 = value[3:0] (rightmost)
load  in  1  one-cycle strobe, captures value into shadow register
lz_blank  in  1  1 = suppress leading zeros
anodes  out  4  digit enables, active-low, one-hot-low or all ones
seven  out  7  segments {a..g}, active-low
frame_done  out  1  one-cycle pulse at the end of each full frame

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: anodes=4'b1111, seven=7'b1111111, frame_done=0, shadow=16'h0000, display reg=16'h0000, state=BLANK, digit idx=0, slot counter=0.
- FSM states: BLANK (all anodes off, seven forced 7'b1111111) and SHOW (selected anode low, seven = decoder(nibble)).
- BLANK lasts exactly DEAD_CYCLES cycles, then SHOW. SHOW lasts exactly REFRESH_DIV cycles, then BLANK with idx+1. idx wraps 3->0.
- Slot length = DEAD_CYCLES+REFRESH_DIV. Frame length = 4*slot.
- The nibble register and anodes update on the same edge that enters SHOW. No cycle shows one digit's segments on another digit's anode.
- anodes in SHOW = ~(4'b0001 << idx).
- load=1 writes value to shadow on that edge. A later load before the frame boundary overwrites the earlier one, so the last load wins.
- Frame boundary: the final SHOW cycle of idx 3. On that edge the display reg takes the shadow reg and frame_done=1 for that one cycle.
- load on the same edge as the boundary: the loaded value does not reach the display reg at that boundary. It goes to the shadow and appears in the next frame.
- Leading-zero blanking: with lz_blank=1, digit k (k>=1) is blanked when display nibbles k..3 are all 4'h0. Digit 0 is never blanked. A blanked digit keeps its slot timing, with anodes=4'b1111 and seven=7'b1111111.
- The shared decoder renders code 4'hF as all segments off. The controller passes the nibble through unchanged.
- en=0: on the next edge, state=BLANK, idx=0, counter=0, anodes=4'b1111, seven=7'b1111111, frame_done=0. Shadow still accepts load; display reg holds.
- en rising: the scan restarts from BLANK, idx 0.
- rst mid-frame: all state returns to reset values on that edge. A load in the reset cycle is ignored.

Decomposition:
- Package disp_pkg holds:
  - scan_state_t enum {BLANK, SHOW}
  - SEG_BLANK = 7'b1111111
  - ANODES_OFF = 4'b1111
  - N_DIGITS
- One sub-module: the team's existing hex decoder display_bin_hex (switch[3:0] -> seven[6:0]), instantiated once. The controller registers its input nibble and muxes SEG_BLANK over its output.
- Counters sized with $clog2(max(REFRESH_DIV, DEAD_CYCLES)).

Test Plan:
- Bench parameters REFRESH_DIV=4, DEAD_CYCLES=2, so frame = 24 cycles.
- Reset, en=1, load value=16'h1234 -> first frame shows 0000 on all four digits, in anode order 1110, 1101, 1011, 0111, each lit 4 cycles with 2 dark cycles before it. frame_done pulses at cycle 24. The next frame shows 4, 3, 2, 1 with decoder codes 1001100, 0000110, 0010010, 1001111.
- lz_blank=1, value=16'h0050 -> digits 0 and 1 show 0000001 and 0100100. Digit slots 2 and 3 keep anodes=1111 and seven=1111111. With value=16'h0000, only digit 0 lights.
- load 16'hAAAA and then 16'hBBBB mid-frame -> the next frame shows only BBBB. A load of 16'hCCCC on the frame_done edge appears one frame later, not in the immediately following frame.
- en dropped for 5 cycles mid-SHOW on idx 2 -> outputs are dark on the next edge. After en returns, the first lit anode is 1110, after exactly 2 dark cycles.
- rst asserted mid-frame alongside load=1, value=16'hFFFF -> all outputs return to reset values. The display shows 0000 afterward, since the load was ignored. A separate load of F shows blank segments with its anode still low.
